// File: rtl/nr_div_seq.sv
// nr_div_seq: sequential non-restoring unsigned divider, one quotient bit per clock plus a final remainder fix.
module nr_div_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           r_state;
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_a_new;
    logic [WIDTH:0]   w_a_fix;
    assign w_m_ext = {1'b0, r_m};
    assign w_shift = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    // The sign of the pre-shift partial remainder alone picks add or subtract.
    assign w_a_new = r_a[WIDTH] ? w_shift + w_m_ext : w_shift - w_m_ext;
    assign w_a_fix = r_a[WIDTH] ? r_a + w_m_ext : r_a;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_q         <= '0;
            r_m         <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && divisor != '0) begin
                        r_a         <= '0;
                        r_q         <= dividend;
                        r_m         <= divisor;
                        r_cnt       <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= RUN;
                    end else if (start) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end
                end
                RUN: begin
                    r_a   <= w_a_new;
                    r_q   <= {r_q[WIDTH-2:0], ~w_a_new[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    r_a       <= w_a_fix;
                    quotient  <= r_q;
                    remainder <= w_a_fix[WIDTH-1:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nr_div_seq.md
Name: nr_div_seq

Overview:
- Sequential non-restoring unsigned divider and its iteration control.
- Drives the add/subtract decision each cycle from the sign of the partial remainder, so the sign test is a one-bit MSB check.
- Produces one quotient bit per clock, then a final remainder correction.
- Sits upstream of result consumers. Handshake is start/busy/done, with registered outputs.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (WIDTH >= 2)
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high; forces IDLE and clears all registers
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
busy  output  1  high while a division is in progress (RUN or FIX)
done  output  1  one-cycle pulse; quotient and remainder are valid from this cycle
quotient  output  WIDTH  registered quotient, held until the next accepted start
remainder  output  WIDTH  registered remainder, held until the next accepted start
div_by_zero  output  1  registered flag for the last result; set when divisor was 0

Behaviour:
- Reset (asynchronous, any time, including mid-division):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal A, Q, M and the counter are cleared.
  - No partial result survives reset.
- Internal registers:
  - A: WIDTH+1 bits, signed two's-complement partial remainder.
  - Q: WIDTH bits, dividend/quotient shift register.
  - M: WIDTH bits, latched divisor, zero-extended to WIDTH+1 for arithmetic.
  - cnt: CNT_W bits.
- States: IDLE, RUN, FIX.
- IDLE:
  - done=0 except in the single cycle after a FIX or divide-by-zero completion.
  - Edge with start=1 and divisor!=0: A=0, Q=dividend, M=divisor, cnt=0, div_by_zero<=0, state->RUN, busy->1.
  - Edge with start=1 and divisor==0: quotient<=all ones, remainder<=dividend, div_by_zero<=1, done<=1. State stays IDLE, busy stays 0.
- RUN: one iteration per edge.
  - Form {A,Q} shifted left by 1, i.e. A' = {A[WIDTH-1:0], Q[WIDTH-1]}.
  - If the sign of the pre-shift A is 0: A = A' - M, else A = A' + M. All arithmetic is modulo 2^(WIDTH+1).
  - Q = {Q[WIDTH-2:0], ~A_new[WIDTH]}.
  - cnt++. When cnt reaches WIDTH-1 at this edge, the state moves to FIX on that same edge.
  - Exactly WIDTH RUN edges occur.
- FIX (one edge):
  - If A[WIDTH]=1, A = A + M.
  - quotient<=Q, remainder<=A_corrected[WIDTH-1:0], done<=1, state->IDLE, busy->0.
- Latency:
  - Accepting edge E0; RUN edges E1..E_WIDTH; FIX edge E_(WIDTH+1).
  - done is high in the cycle after E_(WIDTH+1): WIDTH+1 edges after acceptance.
  - Divide-by-zero: done is high in the cycle after E0.
- done is exactly one cycle wide. It clears on the next edge regardless of start.
- start is ignored while busy=1; operands then are don't-care and have no effect.
- start sampled high in the same cycle done is high (state IDLE): accepted normally, so back-to-back divisions are supported. Old outputs stay held until the new FIX edge.
- Operand inputs are only sampled at acceptance. Changes during RUN or FIX do not affect the result.
- Result invariant for divisor!=0: dividend = quotient*divisor + remainder, with 0 <= remainder < divisor.

Test Plan:
- Reset then idle with start=0 for 5 cycles -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 throughout.
- start with dividend=100, divisor=7 -> busy high for 9 cycles, done pulses in cycle 10 after acceptance edge (WIDTH=8), quotient=14, remainder=2, div_by_zero=0.
- Boundary values:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 255/255 -> quotient=1, remainder=0.
  - 128/3 -> quotient=42, remainder=2.
- 37/0 -> done next cycle, quotient=255, remainder=37, div_by_zero=1, busy never asserts. Then 20/6 -> quotient=3, remainder=2, div_by_zero=0.
- start held high continuously with operands changed to 9/2 mid-RUN of a 200/13 division -> first result 15 r 5. Second acceptance happens in the done cycle, giving 9/2 -> 4 r 1.
- Assert rst asynchronously between clock edges during RUN of 99/4 -> all outputs 0 immediately. After release, 99/4 -> quotient=24, remainder=3 with normal latency.
- Exhaustive sweep over all 65536 operand pairs (WIDTH=8) compared against a reference divide model.
